// File: rtl/ddr_burst_arbiter_if.sv
// Bus bundle between the two channel FIFO controllers, the burst arbiter and the DDR controller.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters and controller.
interface ddr_burst_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
);
  logic              ch0_wr_burst_req;
  logic [ADDR_W-1:0] ch0_wr_burst_addr;
  logic [LEN_W-1:0]  ch0_wr_burst_len;
  logic [DATA_W-1:0] ch0_wr_burst_data;
  logic              ch0_wr_burst_data_req;
  logic              ch0_wr_burst_finish;
  logic              ch0_rd_burst_req;
  logic [ADDR_W-1:0] ch0_rd_burst_addr;
  logic [LEN_W-1:0]  ch0_rd_burst_len;
  logic              ch0_rd_burst_data_valid;
  logic [DATA_W-1:0] ch0_rd_burst_data;
  logic              ch0_rd_burst_finish;

  logic              ch1_wr_burst_req;
  logic [ADDR_W-1:0] ch1_wr_burst_addr;
  logic [LEN_W-1:0]  ch1_wr_burst_len;
  logic [DATA_W-1:0] ch1_wr_burst_data;
  logic              ch1_wr_burst_data_req;
  logic              ch1_wr_burst_finish;
  logic              ch1_rd_burst_req;
  logic [ADDR_W-1:0] ch1_rd_burst_addr;
  logic [LEN_W-1:0]  ch1_rd_burst_len;
  logic              ch1_rd_burst_data_valid;
  logic [DATA_W-1:0] ch1_rd_burst_data;
  logic              ch1_rd_burst_finish;

  logic              m_wr_burst_req;
  logic              m_rd_burst_req;
  logic [ADDR_W-1:0] m_burst_addr;
  logic [LEN_W-1:0]  m_burst_len;
  logic [DATA_W-1:0] m_wr_burst_data;
  logic              m_wr_burst_data_req;
  logic              m_rd_burst_data_valid;
  logic              m_wr_burst_finish;
  logic              m_rd_burst_finish;
  logic [DATA_W-1:0] m_rd_burst_data;

  logic [1:0]        grant_idx;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  ch0_wr_burst_req, ch0_wr_burst_addr, ch0_wr_burst_len, ch0_wr_burst_data,
    output ch0_wr_burst_data_req, ch0_wr_burst_finish,
    input  ch0_rd_burst_req, ch0_rd_burst_addr, ch0_rd_burst_len,
    output ch0_rd_burst_data_valid, ch0_rd_burst_data, ch0_rd_burst_finish,
    input  ch1_wr_burst_req, ch1_wr_burst_addr, ch1_wr_burst_len, ch1_wr_burst_data,
    output ch1_wr_burst_data_req, ch1_wr_burst_finish,
    input  ch1_rd_burst_req, ch1_rd_burst_addr, ch1_rd_burst_len,
    output ch1_rd_burst_data_valid, ch1_rd_burst_data, ch1_rd_burst_finish,
    output m_wr_burst_req, m_rd_burst_req, m_burst_addr, m_burst_len, m_wr_burst_data,
    input  m_wr_burst_data_req, m_rd_burst_data_valid, m_wr_burst_finish, m_rd_burst_finish,
    input  m_rd_burst_data,
    output grant_idx, busy, timeout_err
  );

  modport slave (
    output ch0_wr_burst_req, ch0_wr_burst_addr, ch0_wr_burst_len, ch0_wr_burst_data,
    input  ch0_wr_burst_data_req, ch0_wr_burst_finish,
    output ch0_rd_burst_req, ch0_rd_burst_addr, ch0_rd_burst_len,
    input  ch0_rd_burst_data_valid, ch0_rd_burst_data, ch0_rd_burst_finish,
    output ch1_wr_burst_req, ch1_wr_burst_addr, ch1_wr_burst_len, ch1_wr_burst_data,
    input  ch1_wr_burst_data_req, ch1_wr_burst_finish,
    output ch1_rd_burst_req, ch1_rd_burst_addr, ch1_rd_burst_len,
    input  ch1_rd_burst_data_valid, ch1_rd_burst_data, ch1_rd_burst_finish,
    input  m_wr_burst_req, m_rd_burst_req, m_burst_addr, m_burst_len, m_wr_burst_data,
    output m_wr_burst_data_req, m_rd_burst_data_valid, m_wr_burst_finish, m_rd_burst_finish,
    output m_rd_burst_data,
    input  grant_idx, busy, timeout_err
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR controller burst port between ch0/ch1 write and read requesters.
// Whole bursts are serialised; a watchdog aborts any burst the controller never finishes.
module ddr_burst_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  ddr_burst_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RELEASE} state_t;

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [WD_W-1:0]   wdog;
  logic [3:0]        req_vec;
  logic [1:0]        cand;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  logic [LEN_W-1:0]  pick_len;
  logic              wr_active;
  logic              rd_active;
  logic              fin_match;
  logic              abort;
  logic              done;

  assign req_vec = {bus.ch1_rd_burst_req, bus.ch1_wr_burst_req,
                    bus.ch0_rd_burst_req, bus.ch0_wr_burst_req};

  // Scan starting just after the last grant; offset 4 wraps back to rr_ptr itself.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    cand       = rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!pick_valid && req_vec[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    case (pick_idx)
      2'd0: begin
        pick_addr = bus.ch0_wr_burst_addr;
        pick_len  = bus.ch0_wr_burst_len;
      end
      2'd1: begin
        pick_addr = bus.ch0_rd_burst_addr;
        pick_len  = bus.ch0_rd_burst_len;
      end
      2'd2: begin
        pick_addr = bus.ch1_wr_burst_addr;
        pick_len  = bus.ch1_wr_burst_len;
      end
      default: begin
        pick_addr = bus.ch1_rd_burst_addr;
        pick_len  = bus.ch1_rd_burst_len;
      end
    endcase
  end

  assign wr_active = (state == WR_BUSY);
  assign rd_active = (state == RD_BUSY);

  // Only the finish matching the current burst type counts; anything else is ignored.
  assign fin_match = (wr_active && bus.m_wr_burst_finish) ||
                     (rd_active && bus.m_rd_burst_finish);
  assign abort     = (wr_active || rd_active) && !fin_match &&
                     (wdog == WD_W'(TIMEOUT - 1));
  assign done      = fin_match || abort;

  assign bus.ch0_wr_burst_data_req   = wr_active && (bus.grant_idx == 2'd0) && bus.m_wr_burst_data_req;
  assign bus.ch1_wr_burst_data_req   = wr_active && (bus.grant_idx == 2'd2) && bus.m_wr_burst_data_req;
  assign bus.ch0_rd_burst_data_valid = rd_active && (bus.grant_idx == 2'd1) && bus.m_rd_burst_data_valid;
  assign bus.ch1_rd_burst_data_valid = rd_active && (bus.grant_idx == 2'd3) && bus.m_rd_burst_data_valid;

  assign bus.ch0_wr_burst_finish = wr_active && (bus.grant_idx == 2'd0) && done;
  assign bus.ch1_wr_burst_finish = wr_active && (bus.grant_idx == 2'd2) && done;
  assign bus.ch0_rd_burst_finish = rd_active && (bus.grant_idx == 2'd1) && done;
  assign bus.ch1_rd_burst_finish = rd_active && (bus.grant_idx == 2'd3) && done;

  assign bus.ch0_rd_burst_data = bus.m_rd_burst_data;
  assign bus.ch1_rd_burst_data = bus.m_rd_burst_data;

  always_comb begin
    bus.m_wr_burst_data = '0;
    if (wr_active) begin
      bus.m_wr_burst_data = bus.grant_idx[1] ? bus.ch1_wr_burst_data : bus.ch0_wr_burst_data;
    end
  end

  // rr_ptr resets to 3 so that the first scan starts at ch0 write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= 2'd3;
      wdog            <= '0;
      bus.grant_idx   <= 2'd0;
      bus.m_burst_addr <= '0;
      bus.m_burst_len <= '0;
      bus.m_wr_burst_req <= 1'b0;
      bus.m_rd_burst_req <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.grant_idx    <= pick_idx;
            rr_ptr           <= pick_idx;
            bus.m_burst_addr <= pick_addr;
            bus.m_burst_len  <= pick_len;
            wdog             <= '0;
            bus.busy         <= 1'b1;
            if (pick_idx[0]) begin
              state              <= RD_BUSY;
              bus.m_rd_burst_req <= 1'b1;
            end else begin
              state              <= WR_BUSY;
              bus.m_wr_burst_req <= 1'b1;
            end
          end
        end
        WR_BUSY, RD_BUSY: begin
          if (done) begin
            state              <= RELEASE;
            bus.m_wr_burst_req <= 1'b0;
            bus.m_rd_burst_req <= 1'b0;
            bus.busy           <= 1'b0;
            if (abort) begin
              bus.timeout_err <= 1'b1;
            end
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter: a full-size instance for routing/fairness and a
// TIMEOUT=16 instance for the watchdog; data and grant expectations flow through scoreboard queues.
module tb_ddr_burst_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ddr_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
  ddr_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) tbus ();

  ddr_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ddr_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .bus(tbus)
  );

  int num_checks = 0;
  int num_errors = 0;

  logic [63:0] data_q[$];
  int          grant_q[$];

  logic [ADDR_W-1:0] addr_tab [4];
  logic [LEN_W-1:0]  len_tab  [4];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] fin_vec();
    return {bus.ch1_rd_burst_finish, bus.ch1_wr_burst_finish,
            bus.ch0_rd_burst_finish, bus.ch0_wr_burst_finish};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ch0_wr_burst_req = 0; bus.ch0_wr_burst_addr = '0; bus.ch0_wr_burst_len = '0; bus.ch0_wr_burst_data = '0;
    bus.ch0_rd_burst_req = 0; bus.ch0_rd_burst_addr = '0; bus.ch0_rd_burst_len = '0;
    bus.ch1_wr_burst_req = 0; bus.ch1_wr_burst_addr = '0; bus.ch1_wr_burst_len = '0; bus.ch1_wr_burst_data = '0;
    bus.ch1_rd_burst_req = 0; bus.ch1_rd_burst_addr = '0; bus.ch1_rd_burst_len = '0;
    bus.m_wr_burst_data_req = 0; bus.m_rd_burst_data_valid = 0;
    bus.m_wr_burst_finish = 0; bus.m_rd_burst_finish = 0; bus.m_rd_burst_data = '0;
    tbus.ch0_wr_burst_req = 0; tbus.ch0_wr_burst_addr = '0; tbus.ch0_wr_burst_len = '0; tbus.ch0_wr_burst_data = '0;
    tbus.ch0_rd_burst_req = 0; tbus.ch0_rd_burst_addr = '0; tbus.ch0_rd_burst_len = '0;
    tbus.ch1_wr_burst_req = 0; tbus.ch1_wr_burst_addr = '0; tbus.ch1_wr_burst_len = '0; tbus.ch1_wr_burst_data = '0;
    tbus.ch1_rd_burst_req = 0; tbus.ch1_rd_burst_addr = '0; tbus.ch1_rd_burst_len = '0;
    tbus.m_wr_burst_data_req = 0; tbus.m_rd_burst_data_valid = 0;
    tbus.m_wr_burst_finish = 0; tbus.m_rd_burst_finish = 0; tbus.m_rd_burst_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string tag, output int cycles);
    cycles = 0;
    while (!bus.busy && cycles < 20) begin
      step();
      cycles++;
    end
    check_output(tag, 64'(bus.busy), 64'd1);
  endtask

  // Drives the controller finish for requester idx; leaves the bench one cycle later (RELEASE).
  task automatic finish_burst(input int idx, input string tag);
    if (idx % 2 == 0) bus.m_wr_burst_finish = 1'b1;
    else              bus.m_rd_burst_finish = 1'b1;
    #1;
    check_output(tag, 64'(fin_vec()), 64'(4'b0001 << idx));
    step();
    bus.m_wr_burst_finish = 1'b0;
    bus.m_rd_burst_finish = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] global time limit expired");
  end

  initial begin
    int cyc;
    int cnt0;
    int cnt1;
    int fin_cnt;
    int exp_idx;
    logic [63:0] exp_val;

    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_m_wr_req", 64'(bus.m_wr_burst_req), 64'd0);
    check_output("rst_m_rd_req", 64'(bus.m_rd_burst_req), 64'd0);
    check_output("rst_addr", 64'(bus.m_burst_addr), 64'd0);
    check_output("rst_len", 64'(bus.m_burst_len), 64'd0);
    check_output("rst_grant", 64'(bus.grant_idx), 64'd0);
    check_output("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    check_output("rst_finish", 64'(fin_vec()), 64'd0);

    // Single write: ch0_wr, addr 0x100, len 128
    bus.ch0_wr_burst_req  = 1'b1;
    bus.ch0_wr_burst_addr = 25'h000100;
    bus.ch0_wr_burst_len  = 10'd128;
    step();
    check_output("wr1_req_latency", 64'(bus.m_wr_burst_req), 64'd1);
    check_output("wr1_busy", 64'(bus.busy), 64'd1);
    check_output("wr1_addr", 64'(bus.m_burst_addr), 64'h100);
    check_output("wr1_len", 64'(bus.m_burst_len), 64'd128);
    check_output("wr1_grant", 64'(bus.grant_idx), 64'd0);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 128; i++) begin
      bus.ch0_wr_burst_data = 32'hA000_0000 + 32'(i);
      bus.ch1_wr_burst_data = 32'hDEAD_0000 + 32'(i);
      data_q.push_back(64'(32'hA000_0000 + 32'(i)));
      bus.m_wr_burst_data_req = 1'b1;
      #1;
      if (bus.ch1_wr_burst_data_req) cnt1++;
      if (bus.ch0_wr_burst_data_req) begin
        cnt0++;
        exp_val = (data_q.size() > 0) ? data_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check_output("wr1_data", 64'(bus.m_wr_burst_data), exp_val);
      end
      step();
    end
    bus.m_wr_burst_data_req = 1'b0;
    check_output("wr1_ch0_strobes", 64'(cnt0), 64'd128);
    check_output("wr1_ch1_strobes", 64'(cnt1), 64'd0);
    check_output("wr1_q_empty", 64'(data_q.size()), 64'd0);
    data_q.delete();
    finish_burst(0, "wr1_finish");
    bus.ch0_wr_burst_req = 1'b0;
    check_output("wr1_busy_f1", 64'(bus.busy), 64'd0);
    check_output("wr1_req_f1", 64'(bus.m_wr_burst_req), 64'd0);
    check_output("wr1_finish_f1", 64'(fin_vec()), 64'd0);
    step();
    check_output("wr1_busy_f2", 64'(bus.busy), 64'd0);

    // All four requesting continuously from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr_tab[i] = 25'(32'h10000 * (i + 1) + i);
      len_tab[i]  = 10'(16 + i);
    end
    bus.ch0_wr_burst_addr = addr_tab[0]; bus.ch0_wr_burst_len = len_tab[0];
    bus.ch0_rd_burst_addr = addr_tab[1]; bus.ch0_rd_burst_len = len_tab[1];
    bus.ch1_wr_burst_addr = addr_tab[2]; bus.ch1_wr_burst_len = len_tab[2];
    bus.ch1_rd_burst_addr = addr_tab[3]; bus.ch1_rd_burst_len = len_tab[3];
    bus.ch0_wr_burst_req = 1'b1;
    bus.ch0_rd_burst_req = 1'b1;
    bus.ch1_wr_burst_req = 1'b1;
    bus.ch1_rd_burst_req = 1'b1;
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    for (int b = 0; b < 5; b++) begin
      wait_busy("rr_busy", cyc);
      check_output("rr_gap", 64'(cyc), (b == 0) ? 64'd1 : 64'd2);
      exp_idx = grant_q.pop_front();
      check_output("rr_grant", 64'(bus.grant_idx), 64'(exp_idx));
      check_output("rr_addr", 64'(bus.m_burst_addr), 64'(addr_tab[exp_idx]));
      check_output("rr_len", 64'(bus.m_burst_len), 64'(len_tab[exp_idx]));
      check_output("rr_req_type", 64'({bus.m_rd_burst_req, bus.m_wr_burst_req}),
                   (exp_idx % 2 == 1) ? 64'b10 : 64'b01);
      step();
      finish_burst(exp_idx, "rr_finish");
    end
    bus.ch0_wr_burst_req = 1'b0;
    bus.ch0_rd_burst_req = 1'b0;
    bus.ch1_wr_burst_req = 1'b0;
    bus.ch1_rd_burst_req = 1'b0;
    step();
    step();

    // Read routing: ch1_rd, 128 incrementing beats
    do_reset();
    bus.ch1_rd_burst_req  = 1'b1;
    bus.ch1_rd_burst_addr = 25'h001234;
    bus.ch1_rd_burst_len  = 10'd128;
    wait_busy("rd_busy", cyc);
    check_output("rd_grant", 64'(bus.grant_idx), 64'd3);
    check_output("rd_m_req", 64'(bus.m_rd_burst_req), 64'd1);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 128; i++) begin
      bus.m_rd_burst_data       = 32'h5000_0000 + 32'(i);
      bus.m_rd_burst_data_valid = 1'b1;
      data_q.push_back(64'(32'h5000_0000 + 32'(i)));
      #1;
      if (bus.ch0_rd_burst_data_valid) cnt0++;
      if (bus.ch1_rd_burst_data_valid) begin
        cnt1++;
        exp_val = (data_q.size() > 0) ? data_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check_output("rd_data", 64'(bus.ch1_rd_burst_data), exp_val);
      end
      step();
    end
    bus.m_rd_burst_data_valid = 1'b0;
    check_output("rd_ch1_valid", 64'(cnt1), 64'd128);
    check_output("rd_ch0_valid", 64'(cnt0), 64'd0);
    check_output("rd_q_empty", 64'(data_q.size()), 64'd0);
    data_q.delete();
    finish_burst(3, "rd_finish");
    bus.ch1_rd_burst_req = 1'b0;

    // Spurious read finish during WR_BUSY, then ch1_wr dropping req mid-burst
    bus.ch0_wr_burst_req  = 1'b1;
    bus.ch0_wr_burst_addr = 25'h000042;
    bus.ch0_wr_burst_len  = 10'd4;
    wait_busy("sp_busy", cyc);
    check_output("sp_grant", 64'(bus.grant_idx), 64'd0);
    bus.m_rd_burst_finish = 1'b1;
    #1;
    check_output("sp_no_finish", 64'(fin_vec()), 64'd0);
    step();
    bus.m_rd_burst_finish = 1'b0;
    check_output("sp_still_busy", 64'(bus.busy), 64'd1);
    check_output("sp_still_req", 64'(bus.m_wr_burst_req), 64'd1);
    finish_burst(0, "sp_finish");
    bus.ch0_wr_burst_req = 1'b0;
    bus.ch1_wr_burst_req  = 1'b1;
    bus.ch1_wr_burst_addr = 25'h0ABCDE;
    bus.ch1_wr_burst_len  = 10'd8;
    wait_busy("drop_busy", cyc);
    check_output("drop_grant", 64'(bus.grant_idx), 64'd2);
    check_output("drop_addr", 64'(bus.m_burst_addr), 64'h0ABCDE);
    bus.ch1_wr_burst_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_output("drop_still_busy", 64'(bus.busy), 64'd1);
    check_output("drop_still_req", 64'(bus.m_wr_burst_req), 64'd1);
    finish_burst(2, "drop_finish");

    // Reset in the middle of RD_BUSY
    do_reset();
    bus.ch0_rd_burst_req  = 1'b1;
    bus.ch0_rd_burst_addr = 25'h000777;
    bus.ch0_rd_burst_len  = 10'd64;
    wait_busy("mrst_busy", cyc);
    check_output("mrst_grant", 64'(bus.grant_idx), 64'd1);
    bus.m_rd_burst_data_valid = 1'b1;
    rst = 1'b1;
    step();
    check_output("mrst_busy0", 64'(bus.busy), 64'd0);
    check_output("mrst_req0", 64'(bus.m_rd_burst_req), 64'd0);
    check_output("mrst_grant0", 64'(bus.grant_idx), 64'd0);
    check_output("mrst_addr0", 64'(bus.m_burst_addr), 64'd0);
    check_output("mrst_len0", 64'(bus.m_burst_len), 64'd0);
    check_output("mrst_valid0", 64'(bus.ch0_rd_burst_data_valid), 64'd0);
    check_output("mrst_finish0", 64'(fin_vec()), 64'd0);
    rst = 1'b0;
    bus.m_rd_burst_data_valid = 1'b0;
    bus.ch0_wr_burst_req = 1'b1;
    bus.ch1_wr_burst_req = 1'b1;
    bus.ch1_rd_burst_req = 1'b1;
    wait_busy("mrst_rebusy", cyc);
    check_output("mrst_first_grant", 64'(bus.grant_idx), 64'd0);
    finish_burst(0, "mrst_finish");
    bus.ch0_wr_burst_req = 1'b0;
    bus.ch0_rd_burst_req = 1'b0;
    bus.ch1_wr_burst_req = 1'b0;
    bus.ch1_rd_burst_req = 1'b0;
    step();

    // Watchdog on the TIMEOUT=16 instance
    do_reset();
    tbus.ch0_wr_burst_req  = 1'b1;
    tbus.ch0_wr_burst_addr = 25'h000077;
    tbus.ch0_wr_burst_len  = 10'd8;
    cnt0 = 0;
    fin_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tbus.m_wr_burst_req) cnt0++;
      if (tbus.ch0_wr_burst_finish) begin
        fin_cnt++;
        tbus.ch0_wr_burst_req = 1'b0;
      end
    end
    check_output("to_req_cycles", 64'(cnt0), 64'd16);
    check_output("to_finish_pulses", 64'(fin_cnt), 64'd1);
    check_output("to_err_set", 64'(tbus.timeout_err), 64'd1);
    check_output("to_busy_low", 64'(tbus.busy), 64'd0);
    tbus.ch0_rd_burst_req  = 1'b1;
    tbus.ch0_rd_burst_addr = 25'h000099;
    tbus.ch0_rd_burst_len  = 10'd2;
    cyc = 0;
    while (!tbus.busy && cyc < 20) begin
      step();
      cyc++;
    end
    check_output("to_next_busy", 64'(tbus.busy), 64'd1);
    check_output("to_next_grant", 64'(tbus.grant_idx), 64'd1);
    check_output("to_next_addr", 64'(tbus.m_burst_addr), 64'h99);
    check_output("to_err_sticky", 64'(tbus.timeout_err), 64'd1);
    check_output("main_err_clear", 64'(bus.timeout_err), 64'd0);
    tbus.m_rd_burst_finish = 1'b1;
    #1;
    check_output("to_next_finish", 64'(tbus.ch0_rd_burst_finish), 64'd1);
    step();
    tbus.m_rd_burst_finish = 1'b0;
    tbus.ch0_rd_burst_req  = 1'b0;
    step();
    check_output("to_err_still", 64'(tbus.timeout_err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
